key_event_enc: RTL and testbench

Converts the debounced 16-bit keypad state from the matrix scanner into a stream of discrete make/break events (key index plus direction), buffered in a small FIFO behind a valid/ready handshake. It sits between the keypad scanner (its `btn` vector and once-per-round sync strobe) and the consumers: the 7-segment display, the calculator and game control logic. Those consumers then see each press and each release exactly once, instead of polling a level vector.

---
 rtl/key_pkg.sv | 24 ++
 rtl/key_evt_fifo.sv | 49 ++++
 rtl/key_event_enc.sv | 118 +++++++++++
 tb/tb_key_event_enc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types for the keypad event encoder: key geometry, event record and FSM states.
package key_pkg;

  localparam int KEY_N = 16;
  localparam int KEY_W = 4;

  typedef struct packed {
    logic             make;
    logic [KEY_W-1:0] code;
  } key_evt_t;

  typedef enum logic {IDLE, EMIT} key_state_t;

  // Index of the least significant set bit; zero when no bit is set.
  function automatic logic [KEY_W-1:0] lowest_set(input logic [KEY_N-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small circular event FIFO; full/empty come from pointer equality plus a wrap bit.
module key_evt_fifo
  import key_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = key_evt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/key_event_enc.sv
// Turns debounced keypad levels into queued make/break events, one key per cycle,
// lowest index first, behind a valid/ready handshake.
module key_event_enc
  import key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_N-1:0] btn,
  input  logic             sync,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [KEY_W-1:0] ev_code,
  output logic             ev_make,
  output logic             key_down,
  output logic             dropped
);

  logic             r_sync_q;
  logic             r_cap_req;
  logic             r_dropped;
  logic [KEY_N-1:0] r_snap;
  logic [KEY_N-1:0] r_make_m;
  logic [KEY_N-1:0] r_brk_m;
  key_state_t       r_state;

  key_state_t       w_state_nxt;
  logic             w_rise;
  logic             w_cap;
  logic             w_emit;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [KEY_N-1:0] w_pend;
  logic [KEY_N-1:0] w_bit;
  logic [KEY_W-1:0] w_idx;
  key_evt_t         w_evt;
  key_evt_t         w_head;

  assign w_rise = sync & ~r_sync_q;
  assign w_pend = r_make_m | r_brk_m;
  // A new snapshot is only taken once every event of the previous one is queued.
  assign w_cap  = (w_rise | r_cap_req) & ~(|w_pend);
  assign w_idx  = lowest_set(w_pend);
  assign w_bit  = KEY_N'(1) << w_idx;
  assign w_pop  = ev_valid & ev_ready;

  assign w_evt.make = r_make_m[w_idx];
  assign w_evt.code = w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      IDLE: if (w_cap && |(btn ^ r_snap)) w_state_nxt = EMIT;
      EMIT: begin
        if (|w_pend && (~w_full || w_pop)) begin
          w_emit = 1'b1;
          if (!(|(w_pend & ~w_bit))) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_q  <= 1'b0;
      r_cap_req <= 1'b0;
      r_dropped <= 1'b0;
      r_snap    <= '0;
      r_make_m  <= '0;
      r_brk_m   <= '0;
    end else begin
      r_sync_q  <= sync;
      r_dropped <= w_rise & r_cap_req;
      if (w_cap) begin
        r_cap_req <= 1'b0;
        r_snap    <= btn;
        r_make_m  <= btn & ~r_snap;
        r_brk_m   <= ~btn & r_snap;
      end else begin
        if (w_rise) r_cap_req <= 1'b1;
        if (w_emit) begin
          r_make_m <= r_make_m & ~w_bit;
          r_brk_m  <= r_brk_m & ~w_bit;
        end
      end
    end
  end

  key_evt_fifo #(
    .DEPTH(DEPTH),
    .T    (key_evt_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_emit),
    .push_data(w_evt),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  assign ev_valid = ~w_empty;
  assign ev_code  = w_head.code;
  assign ev_make  = w_head.make;
  assign key_down = |r_snap;
  assign dropped  = r_dropped;

endmodule

// File: tb/tb_key_event_enc.sv
// Self-checking bench for key_event_enc: vector table plus stall, drop and reset sequences.
module tb_key_event_enc;
  import key_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] btn = '0;
  logic        sync = 1'b0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic        ev_make;
  logic        key_down;
  logic        dropped;

  int testsRun = 0;
  int testsFailed = 0;
  int popCount = 0;
  int dropCount = 0;
  key_evt_t sbQueue[$];

  typedef struct {
    logic [15:0] btnVal;
    int          expCount;
    logic        expKeyDown;
  } vec_t;

  key_event_enc #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .sync    (sync),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_code (ev_code),
    .ev_make (ev_make),
    .key_down(key_down),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: events for a level change, in ascending key index order.
  task automatic pushEvents(input logic [15:0] oldB, input logic [15:0] newB);
    key_evt_t e;
    for (int i = 0; i < 16; i++) begin
      if (oldB[i] != newB[i]) begin
        e.make = newB[i];
        e.code = 4'(i);
        sbQueue.push_back(e);
      end
    end
  endtask

  // Drive btn and a one-cycle sync pulse; returns #1 after the capture edge.
  task automatic applyStimulus(input logic [15:0] btnVal);
    btn  = btnVal;
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  task automatic waitDrain(input int limit, output int cycles);
    cycles = 0;
    while (sbQueue.size() != 0 && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Consumer side of the scoreboard: a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      popCount++;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedEvent", {27'd0, ev_make, ev_code}, 32'hFFFF_FFFF);
      end else begin
        key_evt_t exp;
        exp = sbQueue.pop_front();
        checkOutput("event", {27'd0, ev_make, ev_code}, {27'd0, exp});
      end
    end
    if (rst_n && dropped) dropCount++;
  end

  initial begin
    vec_t vecs[8];
    logic [15:0] modelSnap;
    int cycles;
    int popStart;

    vecs[0] = '{16'h0000, 0,  1'b0};
    vecs[1] = '{16'h0020, 1,  1'b1};
    vecs[2] = '{16'h8001, 3,  1'b1};
    vecs[3] = '{16'h8001, 0,  1'b1};
    vecs[4] = '{16'h0000, 2,  1'b0};
    vecs[5] = '{16'hFFFF, 16, 1'b1};
    vecs[6] = '{16'h5555, 8,  1'b1};
    vecs[7] = '{16'h0000, 8,  1'b0};

    #2 rst_n = 1'b0;
    #1;
    checkOutput("resetValid", 32'(ev_valid), 0);
    checkOutput("resetCode", 32'(ev_code), 0);
    checkOutput("resetMake", 32'(ev_make), 0);
    checkOutput("resetKeyDown", 32'(key_down), 0);
    checkOutput("resetDropped", 32'(dropped), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postResetValid", 32'(ev_valid), 0);

    modelSnap = '0;
    ev_ready  = 1'b1;
    for (int v = 0; v < 8; v++) begin
      popStart = popCount;
      pushEvents(modelSnap, vecs[v].btnVal);
      modelSnap = vecs[v].btnVal;
      applyStimulus(vecs[v].btnVal);
      checkOutput("validAfterCapture", 32'(ev_valid), 0);
      if (vecs[v].expCount == 0) begin
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("noEventValid", 32'(ev_valid), 0);
      end else begin
        waitDrain(40, cycles);
        checkOutput("drainCycles", 32'(cycles), 32'(vecs[v].expCount + 1));
      end
      @(posedge clk); #1;
      checkOutput("eventCount", 32'(popCount - popStart), 32'(vecs[v].expCount));
      checkOutput("keyDown", 32'(key_down), 32'(vecs[v].expKeyDown));
      checkOutput("idleValid", 32'(ev_valid), 0);
    end

    // Stall with six keys pressed at once, then merge two further capture requests.
    ev_ready  = 1'b0;
    dropCount = 0;
    popStart  = popCount;
    pushEvents(modelSnap, 16'h003F);
    applyStimulus(16'h003F);
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("stallValid", 32'(ev_valid), 1);
    checkOutput("stallHead", {27'd0, ev_make, ev_code}, {27'd0, 1'b1, 4'd0});
    checkOutput("stallKeyDown", 32'(key_down), 1);
    applyStimulus(16'h0040);
    checkOutput("firstReqNoDrop", 32'(dropped), 0);
    @(posedge clk); #1;
    applyStimulus(16'h00C0);
    checkOutput("dropPulse", 32'(dropped), 1);
    @(posedge clk); #1;
    checkOutput("dropOneCycle", 32'(dropped), 0);
    checkOutput("dropCount", 32'(dropCount), 1);
    checkOutput("stallNoPop", 32'(popCount - popStart), 0);
    pushEvents(16'h003F, 16'h00C0);
    modelSnap = 16'h00C0;
    ev_ready  = 1'b1;
    waitDrain(80, cycles);
    checkOutput("stallDrained", 32'(sbQueue.size()), 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("stallEventCount", 32'(popCount - popStart), 14);
    checkOutput("stallIdleValid", 32'(ev_valid), 0);

    // Reset while an event is waiting at the head.
    ev_ready = 1'b0;
    applyStimulus(16'h00C1);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("preResetValid", 32'(ev_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetValid", 32'(ev_valid), 0);
    checkOutput("asyncResetKeyDown", 32'(key_down), 0);
    sbQueue.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    modelSnap = '0;
    popStart  = popCount;
    pushEvents(modelSnap, 16'h00C1);
    modelSnap = 16'h00C1;
    ev_ready  = 1'b1;
    applyStimulus(16'h00C1);
    waitDrain(40, cycles);
    checkOutput("reMakeCycles", 32'(cycles), 4);
    @(posedge clk); #1;
    checkOutput("reMakeCount", 32'(popCount - popStart), 3);
    checkOutput("reMakeKeyDown", 32'(key_down), 1);
    checkOutput("finalQueue", 32'(sbQueue.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
